// File: rtl/capture_deserializer_fifo.sv
// Serial-to-word deserializer (LSB first) feeding a DEPTH-entry valid/ready FIFO.
// Optional macro CAPTURE_PARITY_EN adds a stored even-parity bit per word on port word_par.
module capture_deserializer_fifo #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din,
  input  logic                     din_vld,
  input  logic                     flush,
  output logic [WORD_W-1:0]        word_data,
  output logic                     word_vld,
  input  logic                     word_rdy,
  output logic [$clog2(DEPTH):0]   fill,
`ifdef CAPTURE_PARITY_EN
  output logic                     overflow,
  output logic                     word_par
`else
  output logic                     overflow
`endif
);

  localparam int CW = $clog2(WORD_W);
  localparam int AW = $clog2(DEPTH);
`ifdef CAPTURE_PARITY_EN
  localparam int DW = WORD_W + 1;
`else
  localparam int DW = WORD_W;
`endif
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

  logic [CW-1:0]     r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              r_ovf;
  logic [DW-1:0]     r_mem [DEPTH];

  logic [WORD_W-1:0] w_word;
  logic [DW-1:0]     w_entry;
  logic [DW-1:0]     w_head;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_wr;

  // The completing bit is merged here so the pushed word includes it on the same edge.
  always_comb begin
    w_word        = r_shift;
    w_word[r_cnt] = din;
  end

`ifdef CAPTURE_PARITY_EN
  assign w_entry = {^w_word, w_word};
`else
  assign w_entry = w_word;
`endif

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = din_vld && !flush && (r_cnt == LAST_BIT);
  assign w_pop   = !w_empty && word_rdy && !flush;
  // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ovf   <= 1'b0;
    end else if (flush) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (din_vld) begin
        r_shift <= w_word;
        r_cnt   <= (r_cnt == LAST_BIT) ? '0 : r_cnt + 1'b1;
      end
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= w_entry;
  end

  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign word_vld  = !w_empty;
  assign word_data = word_vld ? w_head[WORD_W-1:0] : '0;
  assign fill      = r_wptr - r_rptr;
  assign overflow  = r_ovf;
`ifdef CAPTURE_PARITY_EN
  assign word_par  = word_vld & w_head[WORD_W];
`endif

endmodule

// File: tb/tb_capture_deserializer_fifo.sv
// Scoreboard bench for capture_deserializer_fifo; word_par is checked when CAPTURE_PARITY_EN is defined.
module tb_capture_deserializer_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_vld = 1'b0;
  logic       flush = 1'b0;
  logic       word_rdy = 1'b0;
  logic [7:0] word_data;
  logic       word_vld;
  logic [2:0] fill;
  logic       overflow;
`ifdef CAPTURE_PARITY_EN
  logic       word_par;
`endif

  int         passCount = 0;
  int         checkCount = 0;
  logic [7:0] q[$];
  logic       expOvf = 1'b0;

  capture_deserializer_fifo #(.WORD_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .flush(flush),
    .word_data(word_data), .word_vld(word_vld), .word_rdy(word_rdy), .fill(fill),
`ifdef CAPTURE_PARITY_EN
    .overflow(overflow), .word_par(word_par)
`else
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts one word in LSB first and records the scoreboard expectation.
  task automatic sendWord(input logic [7:0] w, input int gap);
    for (int k = 0; k < 8; k++) begin
      din = w[k];
      din_vld = 1'b1;
      tick();
      din_vld = 1'b0;
      din = 1'b0;
      if (k < 7) repeat (gap) tick();
    end
    if (q.size() < 4) q.push_back(w);
    else expOvf = 1'b1;
  endtask

  task automatic test_reset();
    din = 1'b1;
    din_vld = 1'b1;
    repeat (3) tick();
    din_vld = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    checkCount++;
    if ({word_vld, word_data, fill, overflow} !== 13'd0)
      $display("[TB] FAIL reset_outputs: got vld=%b data=%h fill=%0d ovf=%b required all 0", word_vld, word_data, fill, overflow);
    else passCount++;
    tick();
    rst_n = 1'b1;
    tick();
    sendWord(8'h3C, 0);
    checkCount++;
    if (word_vld !== 1'b1 || word_data !== 8'h3C || fill !== 3'd1)
      $display("[TB] FAIL reset_fresh_word: got vld=%b data=%h fill=%0d required 1/3c/1", word_vld, word_data, fill);
    else passCount++;
    word_rdy = 1'b1;
    void'(q.pop_front());
    tick();
    word_rdy = 1'b0;
    checkCount++;
    if (word_vld !== 1'b0 || fill !== 3'd0)
      $display("[TB] FAIL reset_pop: got vld=%b fill=%0d required 0/0", word_vld, fill);
    else passCount++;
  endtask

  task automatic test_basic();
    sendWord(8'h8D, 0);
    checkCount++;
    if (word_vld !== 1'b1 || word_data !== q[0] || fill !== 3'd1 || overflow !== 1'b0)
      $display("[TB] FAIL basic_word: got vld=%b data=%h fill=%0d ovf=%b required 1/%h/1/0", word_vld, word_data, fill, overflow, q[0]);
    else passCount++;
`ifdef CAPTURE_PARITY_EN
    checkCount++;
    if (word_par !== ^q[0])
      $display("[TB] FAIL basic_parity: got %b required %b", word_par, ^q[0]);
    else passCount++;
`endif
    word_rdy = 1'b1;
    while (q.size() > 0) begin
      checkCount++;
      if (word_vld !== 1'b1 || word_data !== q[0])
        $display("[TB] FAIL basic_drain: got vld=%b data=%h required 1/%h", word_vld, word_data, q[0]);
      else passCount++;
      void'(q.pop_front());
      tick();
    end
    word_rdy = 1'b0;
    checkCount++;
    if (word_vld !== 1'b0 || word_data !== 8'h00)
      $display("[TB] FAIL basic_empty: got vld=%b data=%h required 0/00", word_vld, word_data);
    else passCount++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) sendWord(8'(i), 0);
    checkCount++;
    if (fill !== 3'd4 || overflow !== expOvf || word_data !== q[0])
      $display("[TB] FAIL overflow_full: got fill=%0d ovf=%b head=%h required 4/%b/%h", fill, overflow, word_data, expOvf, q[0]);
    else passCount++;
    word_rdy = 1'b1;
    while (q.size() > 0) begin
      checkCount++;
      if (word_vld !== 1'b1 || word_data !== q[0] || fill !== 3'(q.size()))
        $display("[TB] FAIL overflow_drain: got vld=%b data=%h fill=%0d required 1/%h/%0d", word_vld, word_data, fill, q[0], q.size());
      else passCount++;
      void'(q.pop_front());
      tick();
    end
    word_rdy = 1'b0;
    checkCount++;
    if (word_vld !== 1'b0 || overflow !== 1'b1 || fill !== 3'd0)
      $display("[TB] FAIL overflow_sticky: got vld=%b ovf=%b fill=%0d required 0/1/0", word_vld, overflow, fill);
    else passCount++;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] w5;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    expOvf = 1'b0;
    checkCount++;
    if (overflow !== 1'b0 || fill !== 3'd0)
      $display("[TB] FAIL flush_ovf_clear: got ovf=%b fill=%0d required 0/0", overflow, fill);
    else passCount++;
    for (int i = 1; i <= 4; i++) sendWord(8'(i), 0);
    w5 = 8'h05;
    for (int k = 0; k < 7; k++) begin
      din = w5[k];
      din_vld = 1'b1;
      tick();
    end
    din = w5[7];
    word_rdy = 1'b1;
    checkCount++;
    if (word_data !== q[0])
      $display("[TB] FAIL pushpop_head: got %h required %h", word_data, q[0]);
    else passCount++;
    void'(q.pop_front());
    q.push_back(w5);
    tick();
    din_vld = 1'b0;
    word_rdy = 1'b0;
    checkCount++;
    if (fill !== 3'd4 || overflow !== 1'b0 || word_data !== q[0])
      $display("[TB] FAIL pushpop_full: got fill=%0d ovf=%b head=%h required 4/0/%h", fill, overflow, word_data, q[0]);
    else passCount++;
    word_rdy = 1'b1;
    while (q.size() > 0) begin
      checkCount++;
      if (word_vld !== 1'b1 || word_data !== q[0])
        $display("[TB] FAIL pushpop_drain: got vld=%b data=%h required 1/%h", word_vld, word_data, q[0]);
      else passCount++;
      void'(q.pop_front());
      tick();
    end
    word_rdy = 1'b0;
    checkCount++;
    if (word_vld !== 1'b0)
      $display("[TB] FAIL pushpop_empty: got vld=%b required 0", word_vld);
    else passCount++;
  endtask

  task automatic test_flush();
    sendWord(8'h55, 0);
    din = 1'b0;
    din_vld = 1'b1;
    repeat (3) tick();
    din = 1'b1;
    flush = 1'b1;
    word_rdy = 1'b1;
    tick();
    flush = 1'b0;
    din_vld = 1'b0;
    word_rdy = 1'b0;
    q.delete();
    expOvf = 1'b0;
    checkCount++;
    if (fill !== 3'd0 || overflow !== 1'b0 || word_vld !== 1'b0)
      $display("[TB] FAIL flush_clear: got fill=%0d ovf=%b vld=%b required 0/0/0", fill, overflow, word_vld);
    else passCount++;
    sendWord(8'hFF, 0);
    checkCount++;
    if (word_vld !== 1'b1 || word_data !== q[0] || fill !== 3'd1)
      $display("[TB] FAIL flush_fresh: got vld=%b data=%h fill=%0d required 1/%h/1", word_vld, word_data, fill, q[0]);
    else passCount++;
    word_rdy = 1'b1;
    void'(q.pop_front());
    tick();
    word_rdy = 1'b0;
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    int gaps [7] = '{2, 1, 2, 2, 1, 2, 2};
    w = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        checkCount++;
        if (word_vld !== 1'b0)
          $display("[TB] FAIL gaps_early: got vld=%b required 0 before last bit", word_vld);
        else passCount++;
      end
      din = w[k];
      din_vld = 1'b1;
      tick();
      din_vld = 1'b0;
      din = ~din;
      if (k < 7) repeat (gaps[k]) tick();
    end
    q.push_back(w);
    checkCount++;
    if (word_vld !== 1'b1 || word_data !== q[0] || fill !== 3'd1)
      $display("[TB] FAIL gaps_word: got vld=%b data=%h fill=%0d required 1/%h/1", word_vld, word_data, fill, q[0]);
    else passCount++;
`ifdef CAPTURE_PARITY_EN
    checkCount++;
    if (word_par !== ^q[0])
      $display("[TB] FAIL gaps_parity: got %b required %b", word_par, ^q[0]);
    else passCount++;
`endif
    word_rdy = 1'b1;
    void'(q.pop_front());
    tick();
    word_rdy = 1'b0;
    checkCount++;
    if (word_vld !== 1'b0 || fill !== 3'd0)
      $display("[TB] FAIL gaps_drained: got vld=%b fill=%0d required 0/0", word_vld, fill);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    for (int i = 0; i < 3; i++) begin
      w = 8'($urandom_range(0, 255));
      sendWord(w, 0);
    end
    word_rdy = 1'b1;
    while (q.size() > 0) begin
      checkCount++;
      if (word_vld !== 1'b1 || word_data !== q[0] || fill !== 3'(q.size()))
        $display("[TB] FAIL b2b_drain: got vld=%b data=%h fill=%0d required 1/%h/%0d", word_vld, word_data, fill, q[0], q.size());
      else passCount++;
`ifdef CAPTURE_PARITY_EN
      checkCount++;
      if (word_par !== ^q[0])
        $display("[TB] FAIL b2b_parity: got %b required %b", word_par, ^q[0]);
      else passCount++;
`endif
      void'(q.pop_front());
      tick();
    end
    word_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_gaps();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
